perf_counters: RTL and testbench

Parametrised performance-counter and syscall-monitor unit for the MIPS pipeline. It counts retired cycles and NUM_EVT per-instruction event lines: unconditional branches, conditional branches, taken conditional branches, and others. It latches the print-integer syscall argument and raises a sticky halt on the exit syscall. It sits beside the WB stage and exposes a registered, index-selected read port to the display/debug logic.

---
 rtl/perf_counters.sv | 138 +++++++++++++
 tb/tb_perf_counters.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counters.sv
// Cycle/event performance counters with syscall print/exit monitor and a registered read port.
// Optional snapshot shadow registers are enabled with `define PERF_SNAPSHOT_EN.
module perf_counters #(
    parameter int WIDTH   = 32,
    parameter int NUM_EVT = 4,
    parameter int SAT     = 0,
    localparam int SW     = $clog2(NUM_EVT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        a_val,
    input  logic [31:0]        b_val,
    input  logic               syscall_t,
    input  logic               run,
    input  logic [NUM_EVT-1:0] evt,
    input  logic               clr,
    input  logic               snap,
    input  logic [SW-1:0]      rd_sel,
    output logic [WIDTH-1:0]   rd_data,
    output logic [WIDTH-1:0]   total_cycles,
    output logic [NUM_EVT:0]   ovf,
    output logic [31:0]        syscall_out,
    output logic               show_valid,
    output logic               halt
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               act, sys_exit, sys_show;
    logic [NUM_EVT:0]   inc;
    logic [WIDTH-1:0]   cnt_q [NUM_EVT+1];
    logic [WIDTH-1:0]   cnt_d [NUM_EVT+1];
    logic [WIDTH-1:0]   rd_src [NUM_EVT+1];
    logic [NUM_EVT:0]   ovf_q, ovf_d;
    logic [WIDTH-1:0]   rd_data_q, rd_data_d;
    logic [31:0]        sys_q, sys_d;
    logic               show_q;

    assign act      = run && (state_q == ST_RUN);
    assign sys_exit = act && syscall_t && (a_val == 32'd10);
    assign sys_show = act && syscall_t && (a_val == 32'd34);
    // Slot 0 is the cycle counter; slot k counts event k-1.
    assign inc      = {evt & {NUM_EVT{act}}, act};

    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN && sys_exit) begin
            state_d = ST_HALTED;
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        for (int k = 0; k <= NUM_EVT; k++) begin
            cnt_d[k] = cnt_q[k];
            if (clr) begin
                cnt_d[k] = '0;
                ovf_d[k] = 1'b0;
            end else if (inc[k]) begin
                if (&cnt_q[k]) begin
                    ovf_d[k] = 1'b1;
                    cnt_d[k] = (SAT != 0) ? cnt_q[k] : '0;
                end else begin
                    cnt_d[k] = cnt_q[k] + WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        sys_d = sys_q;
        if (sys_show) begin
            sys_d = b_val;
        end
    end

`ifdef PERF_SNAPSHOT_EN
    logic [WIDTH-1:0] shd_q [NUM_EVT+1];

    // Shadows capture pre-edge counter values, so clr/increment on the snap edge is excluded.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= NUM_EVT; k++) shd_q[k] <= '0;
        end else if (snap) begin
            for (int k = 0; k <= NUM_EVT; k++) shd_q[k] <= cnt_q[k];
        end
    end

    always_comb begin
        for (int k = 0; k <= NUM_EVT; k++) rd_src[k] = shd_q[k];
    end
`else
    logic unused_snap;
    assign unused_snap = snap;

    always_comb begin
        for (int k = 0; k <= NUM_EVT; k++) rd_src[k] = cnt_q[k];
    end
`endif

    // Out-of-range selects fall through to zero.
    always_comb begin
        rd_data_d = '0;
        for (int k = 0; k <= NUM_EVT; k++) begin
            if (rd_sel == SW'(k)) rd_data_d = rd_src[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            ovf_q     <= '0;
            rd_data_q <= '0;
            sys_q     <= '0;
            show_q    <= 1'b0;
            for (int k = 0; k <= NUM_EVT; k++) cnt_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            ovf_q     <= ovf_d;
            rd_data_q <= rd_data_d;
            sys_q     <= sys_d;
            show_q    <= sys_show;
            for (int k = 0; k <= NUM_EVT; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    assign rd_data      = rd_data_q;
    assign total_cycles = cnt_q[0];
    assign ovf          = ovf_q;
    assign syscall_out  = sys_q;
    assign show_valid   = show_q;
    assign halt         = (state_q == ST_HALTED);

endmodule

// File: tb/tb_perf_counters.sv
// Bench for perf_counters: wrapping and saturating 8-bit instances against a count-based model.
module tb_perf_counters;
    localparam int NE = 4;
    localparam int W  = 8;

    logic        clk = 1'b0;
    logic        rst, syscall_t, run, clr, snap;
    logic [31:0] a_val, b_val;
    logic [NE-1:0] evt;
    logic [2:0]  rd_sel;

    logic [W-1:0] rd_w, tot_w, rd_s, tot_s;
    logic [NE:0]  ovf_w, ovf_s;
    logic [31:0]  sys_w, sys_s;
    logic         show_w, show_s, halt_w, halt_s;

    int checks = 0;
    int fails  = 0;

    // Model: counters kept as unbounded increment counts since last clear.
    longint      m_cnt [NE+1];
    longint      m_shd [NE+1];
    bit          m_halt, m_show;
    logic [31:0] m_sys;
    logic [W-1:0] e_rd_w, e_rd_s;

    always #5 clk = ~clk;

    perf_counters #(.WIDTH(W), .NUM_EVT(NE), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .a_val(a_val), .b_val(b_val), .syscall_t(syscall_t),
        .run(run), .evt(evt), .clr(clr), .snap(snap), .rd_sel(rd_sel),
        .rd_data(rd_w), .total_cycles(tot_w), .ovf(ovf_w), .syscall_out(sys_w),
        .show_valid(show_w), .halt(halt_w));

    perf_counters #(.WIDTH(W), .NUM_EVT(NE), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .a_val(a_val), .b_val(b_val), .syscall_t(syscall_t),
        .run(run), .evt(evt), .clr(clr), .snap(snap), .rd_sel(rd_sel),
        .rd_data(rd_s), .total_cycles(tot_s), .ovf(ovf_s), .syscall_out(sys_s),
        .show_valid(show_s), .halt(halt_s));

    function automatic logic [W-1:0] fw(longint c);
        return W'(c % 256);
    endfunction

    function automatic logic [W-1:0] fs(longint c);
        return (c > 255) ? 8'hFF : W'(c);
    endfunction

    function automatic logic [NE:0] fovf();
        logic [NE:0] v;
        for (int k = 0; k <= NE; k++) v[k] = (m_cnt[k] >= 256);
        return v;
    endfunction

    task automatic idle();
        rst = 0; syscall_t = 0; run = 0; clr = 0; snap = 0;
        a_val = 0; b_val = 0; evt = 0; rd_sel = 0;
    endtask

    task automatic step();
        longint src;
        bit act;
        if (rst) begin
            for (int k = 0; k <= NE; k++) begin m_cnt[k] = 0; m_shd[k] = 0; end
            m_halt = 0; m_show = 0; m_sys = 0; e_rd_w = 0; e_rd_s = 0;
        end else begin
            if (rd_sel <= NE) begin
`ifdef PERF_SNAPSHOT_EN
                src = m_shd[rd_sel];
`else
                src = m_cnt[rd_sel];
`endif
                e_rd_w = fw(src); e_rd_s = fs(src);
            end else begin
                e_rd_w = 0; e_rd_s = 0;
            end
            act = run && !m_halt;
`ifdef PERF_SNAPSHOT_EN
            if (snap) m_shd = m_cnt;
`endif
            if (clr) begin
                for (int k = 0; k <= NE; k++) m_cnt[k] = 0;
            end else if (act) begin
                m_cnt[0]++;
                for (int k = 0; k < NE; k++) if (evt[k]) m_cnt[k+1]++;
            end
            m_show = act && syscall_t && (a_val == 32'd34);
            if (m_show) m_sys = b_val;
            if (act && syscall_t && a_val == 32'd10) m_halt = 1;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle(); rst = 1; step(); rst = 0;
    endtask

    task automatic test_reset();
        idle(); rst = 1; run = 1; evt = '1; clr = 1; syscall_t = 1; a_val = 34; b_val = 32'h1234;
        step(); idle();
        checks++; if (tot_w !== 8'd0) begin fails++; $display("FAIL reset_tot got=%0h exp=0", tot_w); end
        checks++; if (ovf_w !== 5'd0 || ovf_s !== 5'd0) begin fails++; $display("FAIL reset_ovf got=%0h/%0h exp=0", ovf_w, ovf_s); end
        checks++; if (rd_w !== 8'd0) begin fails++; $display("FAIL reset_rd got=%0h exp=0", rd_w); end
        checks++; if (sys_w !== 32'd0) begin fails++; $display("FAIL reset_sys got=%0h exp=0", sys_w); end
        checks++; if (show_w !== 1'b0 || halt_w !== 1'b0) begin fails++; $display("FAIL reset_flags got show=%b halt=%b exp=0/0", show_w, halt_w); end
    endtask

    task automatic test_basic();
        logic [W-1:0] expv [4] = '{8'd10, 8'd0, 8'd10, 8'd0};
        do_reset();
        run = 1; evt = 4'b0101;
        repeat (10) step();
        idle();
        checks++; if (tot_w !== 8'd10) begin fails++; $display("FAIL basic_tot got=%0d exp=10", tot_w); end
        for (int s = 1; s <= 4; s++) begin
            rd_sel = 3'(s);
            step();
            checks++;
            if (rd_w !== e_rd_w) begin fails++; $display("FAIL basic_rd sel=%0d got=%0d exp=%0d", s, rd_w, e_rd_w); end
`ifndef PERF_SNAPSHOT_EN
            checks++;
            if (rd_w !== expv[s-1]) begin fails++; $display("FAIL basic_rd_const sel=%0d got=%0d exp=%0d", s, rd_w, expv[s-1]); end
`endif
        end
    endtask

    task automatic test_overflow();
        do_reset();
        run = 1;
        repeat (257) step();
        idle();
        checks++; if (tot_w !== 8'd1 || ovf_w[0] !== 1'b1) begin fails++; $display("FAIL ovf_wrap got tot=%0d ovf=%b exp tot=1 ovf=1", tot_w, ovf_w[0]); end
        checks++; if (tot_s !== 8'd255 || ovf_s[0] !== 1'b1) begin fails++; $display("FAIL ovf_sat got tot=%0d ovf=%b exp tot=255 ovf=1", tot_s, ovf_s[0]); end
        checks++; if (ovf_w[NE:1] !== 4'd0) begin fails++; $display("FAIL ovf_evt got=%0h exp=0", ovf_w[NE:1]); end
    endtask

    task automatic test_syscall();
        do_reset();
        run = 1; syscall_t = 1; a_val = 34; b_val = 32'hDEADBEEF;
        step();
        checks++; if (sys_w !== 32'hDEADBEEF || show_w !== 1'b1) begin fails++; $display("FAIL show_load got=%0h v=%b exp=deadbeef v=1", sys_w, show_w); end
        syscall_t = 0; step();
        checks++; if (show_w !== 1'b0) begin fails++; $display("FAIL show_pulse got=%b exp=0", show_w); end
        syscall_t = 1; a_val = 5; b_val = 32'h0BADF00D; step();
        checks++; if (sys_w !== 32'hDEADBEEF || show_w !== 1'b0) begin fails++; $display("FAIL show_other got=%0h v=%b exp=deadbeef v=0", sys_w, show_w); end
        idle();
    endtask

    task automatic test_halt();
        do_reset();
        run = 1;
        for (int c = 0; c <= 20; c++) begin
            evt = 4'($urandom);
            syscall_t = (c == 20); a_val = (c == 20) ? 32'd10 : 32'd0;
            step();
        end
        syscall_t = 0; a_val = 0;
        checks++; if (halt_w !== 1'b1 || tot_w !== 8'd21) begin fails++; $display("FAIL halt_rise got halt=%b tot=%0d exp halt=1 tot=21", halt_w, tot_w); end
        evt = 4'hF;
        repeat (5) step();
        checks++; if (tot_w !== 8'd21 || tot_s !== fs(m_cnt[0])) begin fails++; $display("FAIL halt_freeze got=%0d exp=21", tot_w); end
        rd_sel = 3'd1; step();
        checks++; if (rd_w !== e_rd_w) begin fails++; $display("FAIL halt_evt got=%0d exp=%0d", rd_w, e_rd_w); end
        clr = 1; step(); clr = 0;
        checks++; if (tot_w !== 8'd0 || halt_w !== 1'b1) begin fails++; $display("FAIL halt_clr got tot=%0d halt=%b exp 0/1", tot_w, halt_w); end
        rst = 1; step(); rst = 0;
        checks++; if (halt_w !== 1'b0) begin fails++; $display("FAIL halt_rst got=%b exp=0", halt_w); end
        idle();
    endtask

    task automatic test_clr_beats();
        do_reset();
        run = 1; evt = 4'b0001;
        repeat (7) step();
        clr = 1; step(); clr = 0; run = 0; evt = 0;
        rd_sel = 3'd1; step();
        checks++; if (ovf_w !== 5'd0 || tot_w !== 8'd0) begin fails++; $display("FAIL clr_ovf got ovf=%0h tot=%0d exp 0/0", ovf_w, tot_w); end
        checks++; if (rd_w !== e_rd_w) begin fails++; $display("FAIL clr_rd got=%0d exp=%0d", rd_w, e_rd_w); end
        run = 1; evt = '1;
        repeat (3) step();
        rd_sel = 3'(NE + 1); step();
        checks++; if (rd_w !== 8'd0) begin fails++; $display("FAIL rd_oob got=%0h exp=0", rd_w); end
        rd_sel = 3'd7; step();
        checks++; if (rd_s !== 8'd0) begin fails++; $display("FAIL rd_oob7 got=%0h exp=0", rd_s); end
        idle();
    endtask

`ifdef PERF_SNAPSHOT_EN
    task automatic test_snapshot();
        do_reset();
        run = 1; evt = 4'b0001;
        repeat (5) step();
        snap = 1; step(); snap = 0; run = 0; evt = 0;
        rd_sel = 3'd1;
        repeat (3) begin
            step();
            checks++; if (rd_w !== 8'd5) begin fails++; $display("FAIL snap_rd got=%0d exp=5", rd_w); end
        end
        checks++; if (tot_w !== 8'd6) begin fails++; $display("FAIL snap_live got=%0d exp=6", tot_w); end
    endtask
`endif

    task automatic test_random();
        int r;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            clr = ($urandom_range(0, 99) == 0);
            snap = ($urandom_range(0, 9) == 0);
            run = ($urandom_range(0, 3) != 0);
            evt = 4'($urandom);
            rd_sel = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 15);
            syscall_t = (r < 3);
            a_val = (r == 0) ? 32'd10 : (r < 3) ? 32'd34 : 32'($urandom_range(0, 40));
            b_val = $urandom;
            step();
            checks++; if (tot_w !== fw(m_cnt[0]) || tot_s !== fs(m_cnt[0])) begin fails++; $display("FAIL rand_tot i=%0d got=%0h/%0h exp=%0h/%0h", i, tot_w, tot_s, fw(m_cnt[0]), fs(m_cnt[0])); end
            checks++; if (ovf_w !== fovf() || ovf_s !== fovf()) begin fails++; $display("FAIL rand_ovf i=%0d got=%0h/%0h exp=%0h", i, ovf_w, ovf_s, fovf()); end
            checks++; if (rd_w !== e_rd_w || rd_s !== e_rd_s) begin fails++; $display("FAIL rand_rd i=%0d got=%0h/%0h exp=%0h/%0h", i, rd_w, rd_s, e_rd_w, e_rd_s); end
            checks++; if (sys_w !== m_sys || sys_s !== m_sys) begin fails++; $display("FAIL rand_sys i=%0d got=%0h exp=%0h", i, sys_w, m_sys); end
            checks++; if (show_w !== m_show || show_s !== m_show) begin fails++; $display("FAIL rand_show i=%0d got=%b exp=%b", i, show_w, m_show); end
            checks++; if (halt_w !== m_halt || halt_s !== m_halt) begin fails++; $display("FAIL rand_halt i=%0d got=%b exp=%b", i, halt_w, m_halt); end
        end
        idle();
    endtask

    initial begin
        idle();
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_overflow();
        test_syscall();
        test_halt();
        test_clr_beats();
`ifdef PERF_SNAPSHOT_EN
        test_snapshot();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
